// File: rtl/lzy_univ_shreg_if.sv
// lzy_univ_shreg_if: control, data and status bundle for the universal shift register
interface lzy_univ_shreg_if #(parameter int WIDTH = 8);
    logic             En;
    logic [2:0]       Mode;
    logic             Dsr;
    logic             Dsl;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             Zero;
    logic             Sor;
    logic             Sol;
    modport master (output En, Mode, Dsr, Dsl, D, input Q, Qn, Zero, Sor, Sol);
    modport slave  (input En, Mode, Dsr, Dsl, D, output Q, Qn, Zero, Sor, Sol);
endinterface

// File: rtl/lzy_univ_shreg.sv
// lzy_univ_shreg: universal shift register with shift, rotate, load, clear and preset
module lzy_univ_shreg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic              Clk,
    input logic              Rd,
    lzy_univ_shreg_if.slave  bus
);
    logic [WIDTH-1:0] q, q_nxt;
    // next-state selection; a low enable holds Q and keeps Mode out of the path entirely
    always_comb begin
        q_nxt = q;
        if (bus.En) begin
            case (bus.Mode)
                3'b000: q_nxt = q;
                3'b001: q_nxt = {bus.Dsr, q[WIDTH-1:1]};
                3'b010: q_nxt = {q[WIDTH-2:0], bus.Dsl};
                3'b011: q_nxt = bus.D;
                3'b100: q_nxt = {q[0], q[WIDTH-1:1]};
                3'b101: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                3'b110: q_nxt = '0;
                3'b111: q_nxt = '1;
            endcase
        end
    end
    // state register; reset is asynchronous and released unsynchronised by upstream logic
    always_ff @(posedge Clk or negedge Rd) begin
        if (!Rd) q <= RST_VAL;
        else     q <= q_nxt;
    end
    assign bus.Q    = q;
    assign bus.Qn   = ~q;
    assign bus.Zero = (q == '0);
    assign bus.Sor  = q[0];
    assign bus.Sol  = q[WIDTH-1];
endmodule

// File: tb/tb_lzy_univ_shreg.sv
// tb_lzy_univ_shreg: directed and random checks of three register widths against an arithmetic model
module tb_lzy_univ_shreg;
    logic Clk = 1'b0;
    logic Rd  = 1'b1;
    int total = 0;
    int bad   = 0;
    int          w[3]  = '{8, 2, 16};
    logic [15:0] rv[3] = '{16'h0000, 16'h0000, 16'h8001};
    logic [15:0] m[3];

    lzy_univ_shreg_if #(.WIDTH(8))  if8 ();
    lzy_univ_shreg_if #(.WIDTH(2))  if2 ();
    lzy_univ_shreg_if #(.WIDTH(16)) if16 ();

    lzy_univ_shreg #(.WIDTH(8),  .RST_VAL(8'h00))    u8  (.Clk(Clk), .Rd(Rd), .bus(if8));
    lzy_univ_shreg #(.WIDTH(2),  .RST_VAL(2'b00))    u2  (.Clk(Clk), .Rd(Rd), .bus(if2));
    lzy_univ_shreg #(.WIDTH(16), .RST_VAL(16'h8001)) u16 (.Clk(Clk), .Rd(Rd), .bus(if16));

    always #5 Clk = ~Clk;

    // next value computed arithmetically: shifts as divide/multiply by two, rotates re-insert the lost bit
    function automatic logic [15:0] model(input int wd, input logic [15:0] q, input logic en,
                                          input logic [2:0] mode, input logic dsr, input logic dsl,
                                          input logic [15:0] d);
        int mask = (1 << wd) - 1;
        int msb  = 1 << (wd - 1);
        int qi   = int'(q);
        int v    = qi;
        if (!en) return q;
        case (mode)
            3'd1: v = qi / 2 + (dsr ? msb : 0);
            3'd2: v = qi * 2 + int'(dsl);
            3'd3: v = int'(d);
            3'd4: v = qi / 2 + ((qi % 2 == 1) ? msb : 0);
            3'd5: v = qi * 2 + ((qi >= msb) ? 1 : 0);
            3'd6: v = 0;
            3'd7: v = mask;
            default: v = qi;
        endcase
        return 16'(v & mask);
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_unit(input string tag, input int i, input logic [15:0] q, input logic [15:0] qn,
                            input logic z, input logic sr, input logic sl);
        logic [15:0] mask = 16'((1 << w[i]) - 1);
        string t = $sformatf("%s/w%0d", tag, w[i]);
        cmp({t, "/Q"},    q,  m[i]);
        cmp({t, "/Qn"},   qn, ~m[i] & mask);
        cmp({t, "/Zero"}, {15'd0, z},  {15'd0, m[i] == 16'd0});
        cmp({t, "/Sor"},  {15'd0, sr}, {15'd0, m[i][0]});
        cmp({t, "/Sol"},  {15'd0, sl}, {15'd0, m[i][w[i]-1]});
    endtask

    task automatic chk(input string tag);
        chk_unit(tag, 0, 16'(if8.Q),  16'(if8.Qn),  if8.Zero,  if8.Sor,  if8.Sol);
        chk_unit(tag, 1, 16'(if2.Q),  16'(if2.Qn),  if2.Zero,  if2.Sor,  if2.Sol);
        chk_unit(tag, 2, if16.Q,      if16.Qn,      if16.Zero, if16.Sor, if16.Sol);
    endtask

    task automatic drive(input logic en, input logic [2:0] mode, input logic dsr, input logic dsl,
                         input logic [15:0] d);
        if8.En  = en; if8.Mode  = mode; if8.Dsr  = dsr; if8.Dsl  = dsl; if8.D  = d[7:0];
        if2.En  = en; if2.Mode  = mode; if2.Dsr  = dsr; if2.Dsl  = dsl; if2.D  = d[1:0];
        if16.En = en; if16.Mode = mode; if16.Dsr = dsr; if16.Dsl = dsl; if16.D = d;
    endtask

    task automatic step(input string tag, input logic en, input logic [2:0] mode, input logic dsr,
                        input logic dsl, input logic [15:0] d);
        drive(en, mode, dsr, dsl, d);
        @(posedge Clk);
        for (int i = 0; i < 3; i++) m[i] = model(w[i], m[i], en, mode, dsr, dsl, d & 16'((1 << w[i]) - 1));
        #1;
        chk(tag);
    endtask

    task automatic pulse_rst(input string tag);
        #2 Rd = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = rv[i];
        chk(tag);
        #1 Rd = 1'b1;
    endtask

    initial begin
        drive(1'b0, 3'd0, 1'b0, 1'b0, 16'd0);
        #2 Rd = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = rv[i];
        chk("async_rst");
        cmp("rst16_lit", if16.Q, 16'h8001);
        #5 Rd = 1'b1;

        step("load_a5", 1'b1, 3'd3, 1'b0, 1'b0, 16'h00A5);
        step("rr1", 1'b1, 3'd4, 1'b0, 1'b0, 16'h0);
        cmp("rr1_lit", 16'(if8.Q), 16'h00D2);
        step("rr2", 1'b1, 3'd4, 1'b0, 1'b0, 16'h0);
        cmp("rr2_lit", 16'(if8.Q), 16'h0069);
        for (int k = 3; k <= 8; k++) step($sformatf("rr%0d", k), 1'b1, 3'd4, 1'b0, 1'b0, 16'h0);
        cmp("rr8_lit", 16'(if8.Q), 16'h00A5);

        step("load_81", 1'b1, 3'd3, 1'b0, 1'b0, 16'h0081);
        cmp("sol_pre", {15'd0, if8.Sol}, 16'd1);
        step("sl1", 1'b1, 3'd2, 1'b1, 1'b0, 16'hFFFF);
        cmp("sl1_lit", 16'(if8.Q), 16'h0002);
        step("sl2", 1'b1, 3'd2, 1'b1, 1'b0, 16'hFFFF);
        cmp("sl2_lit", 16'(if8.Q), 16'h0004);

        step("load_01", 1'b1, 3'd3, 1'b0, 1'b0, 16'h0001);
        step("sr_dsr1", 1'b1, 3'd1, 1'b1, 1'b0, 16'h0);
        cmp("sr_lit", 16'(if8.Q), 16'h0080);
        for (int k = 0; k < 3; k++) step("hold_en0", 1'b0, 3'd7, 1'b1, 1'b1, 16'hFFFF);
        step("hold_modex", 1'b0, 3'bxxx, 1'b1, 1'b1, 16'hFFFF);
        cmp("hold_lit", 16'(if8.Q), 16'h0080);

        step("preset", 1'b1, 3'd7, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 3'd7, 1'b0, 1'b0, 16'h0);
        @(posedge Clk);
        Rd = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = rv[i];
        chk("rst_at_edge");
        cmp("rst_at_edge_lit", 16'(if8.Q), 16'h0000);
        #2 Rd = 1'b1;
        step("rotl16", 1'b1, 3'd5, 1'b0, 1'b0, 16'h0);
        cmp("rotl16_lit", if16.Q, 16'h0003);
        step("clear", 1'b1, 3'd6, 1'b1, 1'b1, 16'hFFFF);

        step("load_abort", 1'b1, 3'd3, 1'b0, 1'b0, 16'h5A3C);
        step("rot_abort", 1'b1, 3'd4, 1'b0, 1'b0, 16'h0);
        pulse_rst("mid_abort");
        step("after_abort", 1'b1, 3'd5, 1'b0, 1'b0, 16'h0);

        for (int k = 0; k < 300; k++) begin
            step("rand", $urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            if ($urandom_range(0, 24) == 0) pulse_rst("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
